// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side handshake between an output FIFO and its serial drain stage.
// master = drain (pops words), slave = FIFO (supplies empty flag and read data).
interface fifo_uart_tx_if #(
   parameter int unsigned W_DATA = 8
) ();

   logic              empty;
   logic [W_DATA-1:0] rd_data;
   logic              pop;

   modport master (
      input  empty,
      input  rd_data,
      output pop
   );

   modport slave (
      output empty,
      output rd_data,
      input  pop
   );

endinterface

// File: rtl/fifo_uart_tx.sv
// Drains an output FIFO onto an asynchronous serial line: start, data LSB first, stop.
// Optional even-parity bit between data and stop when FIFO_UART_TX_PARITY_EN is defined.
module fifo_uart_tx #(
   parameter int unsigned W_DATA   = 8,
   parameter int unsigned BAUD_DIV = 16,
   parameter int unsigned W_CNT    = 16
) (
   input  logic               clk,
   input  logic               rst,
   fifo_uart_tx_if.master     fifo,
   output logic               tx_o,
   output logic               busy_o,
   output logic [W_CNT-1:0]   frame_cnt_o
);

   localparam int unsigned CntW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam int unsigned IdxW = (W_DATA > 1) ? $clog2(W_DATA) : 1;
   localparam logic [CntW-1:0] BaudLast = CntW'(BAUD_DIV - 1);
   localparam logic [IdxW-1:0] IdxLast  = IdxW'(W_DATA - 1);

   typedef enum logic [2:0] {
      StIdle,
      StPop,
      StWait,
      StStart,
      StData,
`ifdef FIFO_UART_TX_PARITY_EN
      StParity,
`endif
      StStop
   } state_e;

   state_e              state_q, state_d;
   logic [W_DATA-1:0]   shift_q, shift_d;
   logic [IdxW-1:0]     idx_q, idx_d;
   logic [CntW-1:0]     baud_q, baud_d;
   logic [W_CNT-1:0]    frame_cnt_q, frame_cnt_d;
   logic                baud_strobe;
   logic                timed;
`ifdef FIFO_UART_TX_PARITY_EN
   logic                parity_q, parity_d;
`endif

   assign baud_strobe = (baud_q == BaudLast);
   assign busy_o      = (state_q != StIdle);
   assign frame_cnt_o = frame_cnt_q;

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      idx_d       = idx_q;
      frame_cnt_d = frame_cnt_q;
      tx_o        = 1'b1;
      fifo.pop    = 1'b0;
      timed       = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_d    = parity_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (!fifo.empty) state_d = StPop;
         end
         StPop: begin
            fifo.pop = 1'b1;
            state_d  = StWait;
         end
         StWait: begin
            // Read data is valid one cycle after the pop pulse.
            shift_d = fifo.rd_data;
            idx_d   = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_d = ^fifo.rd_data;
`endif
            state_d = StStart;
         end
         StStart: begin
            timed = 1'b1;
            tx_o  = 1'b0;
            if (baud_strobe) state_d = StData;
         end
         StData: begin
            timed = 1'b1;
            tx_o  = shift_q[0];
            if (baud_strobe) begin
               shift_d = shift_q >> 1;
               idx_d   = idx_q + 1'b1;
               if (idx_q == IdxLast) begin
`ifdef FIFO_UART_TX_PARITY_EN
                  state_d = StParity;
`else
                  state_d = StStop;
`endif
               end
            end
         end
`ifdef FIFO_UART_TX_PARITY_EN
         StParity: begin
            timed = 1'b1;
            tx_o  = parity_q;
            if (baud_strobe) state_d = StStop;
         end
`endif
         StStop: begin
            timed = 1'b1;
            if (baud_strobe) begin
               frame_cnt_d = frame_cnt_q + 1'b1;
               state_d     = fifo.empty ? StIdle : StPop;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Bit timer restarts on every state entry and on every bit boundary.
   always_comb begin
      baud_d = baud_q + 1'b1;
      if (!timed || baud_strobe || (state_d != state_q)) baud_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         shift_q     <= '0;
         idx_q       <= '0;
         baud_q      <= '0;
         frame_cnt_q <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
         parity_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         idx_q       <= idx_d;
         baud_q      <= baud_d;
         frame_cnt_q <= frame_cnt_d;
`ifdef FIFO_UART_TX_PARITY_EN
         parity_q    <= parity_d;
`endif
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: W_DATA=8, BAUD_DIV=4, W_CNT=2, behavioural FIFO source.
// Follows FIFO_UART_TX_PARITY_EN to expect the parity bit when the feature is built in.
module tb_fifo_uart_tx;

   localparam int BAUD = 4;
`ifdef FIFO_UART_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int FB = 10 + PAR;
   localparam int L  = FB * BAUD;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tx;
   logic       busy;
   logic [1:0] fcnt;

   int tests = 0;
   int fails = 0;

   logic [7:0] mem [0:31];
   int wr_ptr = 0;
   int rd_ptr = 0;
   int cyc = 0;
   int pop_cnt = 0;
   int pop_bad = 0;
   int pop_cyc [0:31];

   fifo_uart_tx_if #(.W_DATA(8)) fif ();

   fifo_uart_tx #(
      .W_DATA  (8),
      .BAUD_DIV(BAUD),
      .W_CNT   (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo       (fif),
      .tx_o       (tx),
      .busy_o     (busy),
      .frame_cnt_o(fcnt)
   );

   always #5 clk = ~clk;

   assign fif.empty = (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      if (fif.pop && (wr_ptr != rd_ptr)) begin
         fif.rd_data <= mem[rd_ptr[4:0]];
         rd_ptr      <= rd_ptr + 1;
      end
   end

   always @(negedge clk) begin
      cyc++;
      if (fif.pop === 1'b1) begin
         if (pop_cnt < 32) pop_cyc[pop_cnt] = cyc;
         pop_cnt++;
         if (fif.empty) pop_bad++;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] w);
      mem[wr_ptr[4:0]] = w;
      wr_ptr++;
   endtask

   task automatic wait_start(output int waited);
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (tx !== 1'b0 && waited < 200);
   endtask

   function automatic logic [47:0] exp_wave(input logic [7:0] d);
      logic [11:0] bits;
      logic [47:0] w;
      bits    = '1;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[1+i] = d[i];
      if (PAR == 1) bits[9] = ^d;
      w = '0;
      for (int j = 0; j < L; j++) w[j] = bits[j/BAUD];
      return w;
   endfunction

   function automatic logic [7:0] decode(input logic [47:0] w);
      logic [7:0] d;
      for (int i = 0; i < 8; i++) d[i] = w[(1+i)*BAUD + BAUD/2];
      return d;
   endfunction

   // Captures one frame from its first start-bit cycle, then samples frame_cnt one cycle later.
   task automatic frame_check(input string tag, input logic [7:0] d, input int exp_wait,
                              input logic [1:0] exp_fc, output logic [47:0] wave);
      int w;
      wait_start(w);
      wave    = '0;
      wave[0] = tx;
      for (int j = 1; j < L; j++) begin
         @(negedge clk);
         wave[j] = tx;
      end
      @(negedge clk);
      check({tag, "_wait"}, 64'(w), 64'(exp_wait));
      check({tag, "_wave"}, 64'(wave), 64'(exp_wave(d)));
      check({tag, "_data"}, 64'(decode(wave)), 64'(d));
      check({tag, "_fcnt"}, 64'(fcnt), 64'(exp_fc));
   endtask

   initial begin
      logic [47:0] wv;
      int base;
      int w;

      // Reset state, and no pop while reset holds a non-empty FIFO.
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_tx", 64'(tx), 64'(1));
      check("rst_pop", 64'(fif.pop), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_fcnt", 64'(fcnt), 64'(0));
      push(8'hA5);
      repeat (3) @(negedge clk);
      check("rst_nopop", 64'(pop_cnt), 64'(0));

      // Single word 0xA5: pop one cycle after IDLE sees non-empty, start two cycles later.
      rst = 1'b0;
      @(negedge clk);
      check("lat_pop", 64'(fif.pop), 64'(1));
      @(negedge clk);
      check("pop_width", 64'(fif.pop), 64'(0));
      check("wait_busy", 64'(busy), 64'(1));
      check("wait_tx", 64'(tx), 64'(1));
      frame_check("a5", 8'hA5, 1, 2'd1, wv);
      check("a5_idle_busy", 64'(busy), 64'(0));
      check("a5_idle_tx", 64'(tx), 64'(1));
      check("a5_pops", 64'(pop_cnt), 64'(1));

      // Back-to-back: line high for stop + POP + WAIT between frames.
      base = pop_cnt;
      push(8'h00);
      push(8'hFF);
      push(8'h3C);
      frame_check("b0", 8'h00, 3, 2'd2, wv);
      frame_check("b1", 8'hFF, 2, 2'd3, wv);
      frame_check("b2", 8'h3C, 2, 2'd0, wv);
      check("b_pops", 64'(pop_cnt - base), 64'(3));
      check("b_space01", 64'(pop_cyc[base+1] - pop_cyc[base]), 64'(FB*BAUD + 2));
      check("b_space12", 64'(pop_cyc[base+2] - pop_cyc[base+1]), 64'(FB*BAUD + 2));
      check("b_idle_busy", 64'(busy), 64'(0));

      // Parity words: even parity of 0x01 is 1, of 0x03 is 0.
      base = pop_cnt;
      push(8'h01);
      push(8'h03);
      frame_check("p0", 8'h01, 3, 2'd1, wv);
`ifdef FIFO_UART_TX_PARITY_EN
      check("p0_parity", 64'(wv[9*BAUD + BAUD/2]), 64'(1));
`endif
      frame_check("p1", 8'h03, 2, 2'd2, wv);
`ifdef FIFO_UART_TX_PARITY_EN
      check("p1_parity", 64'(wv[9*BAUD + BAUD/2]), 64'(0));
`endif
      check("p_space", 64'(pop_cyc[base+1] - pop_cyc[base]), 64'(FB*BAUD + 2));

      // Reset during data bit 3 of 0x5A; 0x5A is lost, 0xC3 follows in full.
      push(8'h5A);
      push(8'hC3);
      wait_start(w);
      check("mid_found", 64'(w < 200), 64'(1));
      repeat (4*BAUD + 1) @(negedge clk);
      check("mid_bit3", 64'(tx), 64'(1));
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_tx", 64'(tx), 64'(1));
      check("mid_rst_pop", 64'(fif.pop), 64'(0));
      check("mid_rst_busy", 64'(busy), 64'(0));
      check("mid_rst_fcnt", 64'(fcnt), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      frame_check("c3", 8'hC3, 3, 2'd1, wv);
      check("c3_drained", 64'(rd_ptr == wr_ptr), 64'(1));
      check("c3_idle_busy", 64'(busy), 64'(0));

      // Two-bit frame counter wraps 1,2,3,0,1.
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      push(8'h11);
      push(8'h22);
      push(8'h33);
      push(8'h44);
      push(8'h55);
      frame_check("w0", 8'h11, 3, 2'd1, wv);
      frame_check("w1", 8'h22, 2, 2'd2, wv);
      frame_check("w2", 8'h33, 2, 2'd3, wv);
      frame_check("w3", 8'h44, 2, 2'd0, wv);
      frame_check("w4", 8'h55, 2, 2'd1, wv);

      check("pop_while_empty", 64'(pop_bad), 64'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
